dmem_arbiter: RTL

Two-port arbiter that shares the single-port data memory between the CPU load/store path (port 0) and a loader/debug requester (port 1). Each cycle it grants at most one requester and drives the memory's read/write strobes, address and write data from the winner. Read data is registered and returned with a one-cycle valid pulse. The CPU stalls on a denied cycle. The block sits between the CPU's data-memory signals and the `data_memory` instance.

---
 rtl/dmem_arbiter.sv | 83 ++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU (port 0) and a loader/debug port (port 1).
// Define DMEM_ARB_BURST_EN to let a winning port keep the grant for up to MAX_BURST contested cycles.
module dmem_arbiter #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p0_gnt,
   output logic              p1_gnt,
   output logic              p0_rvalid,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p0_rdata,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              cpu_stall,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   typedef enum logic [1:0] {NONE, P0, P1} owner_t;
   owner_t owner_q;
   logic   prio, sel1, keep0, keep1, any_gnt, we;

   if (MAX_BURST < 2) begin : g_bad_burst
      $error("MAX_BURST must be at least 2");
   end

`ifdef DMEM_ARB_BURST_EN
   localparam int            BW   = $clog2(MAX_BURST);
   localparam logic [BW-1:0] BMAX = BW'(MAX_BURST - 1);
   logic [BW-1:0] burst_cnt;
   assign keep0 = owner_q == P0 && burst_cnt < BMAX;
   assign keep1 = owner_q == P1 && burst_cnt < BMAX;
   always_ff @(posedge clk or posedge reset)
      if (reset)
         burst_cnt <= '0;
      else
         burst_cnt <= (any_gnt && owner_q == (p1_gnt ? P1 : P0)) ? burst_cnt + BW'(burst_cnt != BMAX) : '0;
`else
   assign keep0 = 1'b0;
   assign keep1 = 1'b0;
`endif

   // On contention the current burst owner wins if it may, otherwise prio breaks the tie
   assign sel1      = (p0_req & p1_req) ? (keep1 | (~keep0 & prio)) : p1_req;
   assign p0_gnt    = p0_req & ~sel1;
   assign p1_gnt    = p1_req & sel1;
   assign cpu_stall = p0_req & ~p0_gnt;
   assign any_gnt   = p0_gnt | p1_gnt;
   assign we        = p1_gnt ? p1_we : p0_we;
   assign mem_write = any_gnt & we;
   assign mem_read  = any_gnt & ~we;
   assign mem_addr  = p1_gnt ? p1_addr : p0_gnt ? p0_addr : '0;
   assign mem_wdata = p1_gnt ? p1_wdata : p0_gnt ? p0_wdata : '0;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         prio      <= 1'b0;
         owner_q   <= NONE;
         p0_rvalid <= 1'b0;
         p1_rvalid <= 1'b0;
         p0_rdata  <= '0;
         p1_rdata  <= '0;
      end else begin
         p0_rvalid <= p0_gnt & ~p0_we;
         p1_rvalid <= p1_gnt & ~p1_we;
         if (p0_gnt & ~p0_we) p0_rdata <= mem_rdata;
         if (p1_gnt & ~p1_we) p1_rdata <= mem_rdata;
         if (any_gnt) prio <= p0_gnt;
         owner_q <= p1_gnt ? P1 : p0_gnt ? P0 : NONE;
      end
endmodule
